// File: rtl/baud_rate_generator_if.sv
// UART strobe bundle: bit-rate and oversampling strobes.
// Produced by baud_rate_generator, consumed by uart_tx / uart_rx.
interface baud_rate_generator_if;
  logic tx_clk;
  logic rx_clk;

  modport master (
    output tx_clk,
    output rx_clk
  );

  modport slave (
    input tx_clk,
    input rx_clk
  );
endinterface

// File: rtl/baud_rate_generator.sv
// UART strobe generator: rx_clk every RX_DIV clks,
// tx_clk every RX_DIV*OVERSAMPLE clks, phase-locked to rx_clk.
module baud_rate_generator #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int OVERSAMPLE = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  baud_rate_generator_if.master  baud
);

  localparam int OS_RATE = BAUD_RATE * OVERSAMPLE;
  localparam int RX_DIV  = (CLK_FREQ + OS_RATE / 2) / OS_RATE;

  localparam int DW = (RX_DIV > 1) ? $clog2(RX_DIV) : 1;
  localparam int OW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

  localparam logic [DW-1:0] DIV_MAX = DW'(RX_DIV - 1);
  localparam logic [OW-1:0] OS_MAX  = OW'(OVERSAMPLE - 1);

  // Achieved baud rate, for the 2% error warning
  localparam int ACTUAL = CLK_FREQ / ((RX_DIV > 0 ? RX_DIV : 1) * OVERSAMPLE);
  localparam int DIFF   = (ACTUAL > BAUD_RATE) ? ACTUAL - BAUD_RATE
                                               : BAUD_RATE - ACTUAL;

  if (RX_DIV < 2 || OVERSAMPLE < 2) begin : g_bad_div
    $error("baud_rate_generator: RX_DIV=%0d OVERSAMPLE=%0d, both must be >= 2",
           RX_DIV, OVERSAMPLE);
  end

  if (DIFF * 50 > BAUD_RATE) begin : g_baud_err
    $warning("baud_rate_generator: baud error above 2%% (%0d vs %0d)",
             ACTUAL, BAUD_RATE);
  end

  logic [DW-1:0] div_cnt;
  logic [OW-1:0] os_cnt;
  logic          rx_q;
  logic          tx_q;
  logic          div_wrap;
  logic          os_wrap;

  assign div_wrap = (div_cnt == DIV_MAX);
  assign os_wrap  = (os_cnt == OS_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      os_cnt  <= '0;
      rx_q    <= 1'b0;
      tx_q    <= 1'b0;
    end else begin
      rx_q <= div_wrap;
      tx_q <= div_wrap && os_wrap;
      if (div_wrap) begin
        div_cnt <= '0;
        os_cnt  <= os_wrap ? '0 : os_cnt + 1'b1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  assign baud.rx_clk = rx_q;
  assign baud.tx_clk = tx_q;

endmodule

// File: tb/tb_baud_rate_generator.sv
// Scoreboard bench for baud_rate_generator: default and
// 1 MHz / 9600 / x8 instances against an edge-count model.
module tb_baud_rate_generator;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  baud_rate_generator_if bif_a ();
  baud_rate_generator_if bif_b ();

  baud_rate_generator u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .baud  (bif_a.master)
  );

  baud_rate_generator #(
    .CLK_FREQ   (1_000_000),
    .BAUD_RATE  (9600),
    .OVERSAMPLE (8)
  ) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .baud  (bif_b.master)
  );

  typedef struct {
    logic rxa;
    logic txa;
    logic rxb;
    logic txb;
    int   tag;
    int   t;
  } exp_t;

  exp_t sb[$];

  int  t = 0;
  bit  done = 1'b0;
  int  errors = 0;
  int  checks = 0;
  int  rx_cnt = 0;
  int  tx_cnt = 0;

  // Rising edges since release; a strobe follows every multiple of the period
  task automatic step(input logic r, input int tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (rst_n) t++;
    #1;
    rst_n = r;
    if (!r) t = 0;
    e.rxa = (t > 0) && (t % 27 == 0);
    e.txa = (t > 0) && (t % (27 * 16) == 0);
    e.rxb = (t > 0) && (t % 13 == 0);
    e.txb = (t > 0) && (t % (13 * 8) == 0);
    e.tag = tag;
    e.t   = t;
    sb.push_back(e);
  endtask

  task automatic check(input string name, input int act, input int req, input int tt);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s t=%0d got=%0d want=%0d", name, tt, act, req);
    end
  endtask

  initial begin : stim
    int n;
    int r;
    for (int i = 0; i < 5; i++) step(1'b0, 0);
    step(1'b1, 0);
    for (int i = 0; i < 432 * 10; i++) step(1'b1, 2);
    for (int i = 0; i < 200; i++) step(1'b1, 1);
    for (int i = 0; i < 3; i++) step(1'b0, 1);
    for (int i = 0; i < 900; i++) step(1'b1, 1);
    for (int k = 0; k < 6; k++) begin
      n = $urandom_range(1500, 20);
      r = $urandom_range(4, 1);
      for (int i = 0; i < n; i++) step(1'b1, 1);
      for (int i = 0; i < r; i++) step(1'b0, 1);
    end
    for (int i = 0; i < 500; i++) step(1'b1, 1);
    done = 1'b1;
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() == 0) begin
        if (done) break;
        check("queue_empty", 0, 1, t);
      end else begin
        e = sb.pop_front();
        check("rx_a", int'(bif_a.rx_clk), int'(e.rxa), e.t);
        check("tx_a", int'(bif_a.tx_clk), int'(e.txa), e.t);
        check("rx_b", int'(bif_b.rx_clk), int'(e.rxb), e.t);
        check("tx_b", int'(bif_b.tx_clk), int'(e.txb), e.t);
        if (bif_a.tx_clk)
          check("tx_a_aligned_rx", int'(bif_a.rx_clk), 1, e.t);
        if (e.tag == 2) begin
          rx_cnt += int'(bif_a.rx_clk);
          tx_cnt += int'(bif_a.tx_clk);
        end
      end
    end
  end

  initial begin : finisher
    int guard;
    wait (done);
    guard = 0;
    while (sb.size() != 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    #1;
    if (sb.size() != 0) check("drain_timeout", sb.size(), 0, t);
    check("rx_pulses_10_bits", rx_cnt, 160, t);
    check("tx_pulses_10_bits", tx_cnt, 10, t);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
